// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 8-bit pipelined core.
//
// Captures the register-file read ports plus decoded control fields and
// presents them to EX one cycle later. It also does three more things:
// - Detects load-use hazards. It raises stall to freeze PC and IF/ID, and loads
//   a bubble into EX.
// - Applies branch flushes from EX by loading a bubble.
// - Bypasses a same-cycle writeback onto the read operands, because the
//   register file read is combinational and does not see the write yet.
//
// Ports:
//   clk, reset (async, active-low)
//   id_*        decoded instruction currently in ID
//   rf_data1/2  register-file combinational read data
//   wb_*        writeback port (same signals that drive the register file)
//   flush       branch taken in EX; the ID instruction is killed
//   stall       combinational hazard output to PC / IF/ID
//   ex_*        registered fields presented to EX
//   bubble_cnt  saturating count of bubbles inserted (flush or stall)
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DW  = 8,
  parameter int AW  = 3,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           id_valid,
  input  logic [AW-1:0]  id_rs1,
  input  logic [AW-1:0]  id_rs2,
  input  logic           id_rs1_used,
  input  logic           id_rs2_used,
  input  logic [AW-1:0]  id_rd,
  input  logic           id_reg_write,
  input  logic           id_mem_read,
  input  logic           id_mem_write,
  input  logic           id_use_imm,
  input  logic [OPW-1:0] id_alu_op,
  input  logic [DW-1:0]  id_imm,
  input  logic [DW-1:0]  rf_data1,
  input  logic [DW-1:0]  rf_data2,
  input  logic           wb_reg_write,
  input  logic [AW-1:0]  wb_addr,
  input  logic [DW-1:0]  wb_data,
  input  logic           flush,
  output logic           stall,
  output logic           ex_valid,
  output logic           ex_reg_write,
  output logic           ex_mem_read,
  output logic           ex_mem_write,
  output logic           ex_use_imm,
  output logic [OPW-1:0] ex_alu_op,
  output logic [AW-1:0]  ex_rs1,
  output logic [AW-1:0]  ex_rs2,
  output logic [AW-1:0]  ex_rd,
  output logic [DW-1:0]  ex_a,
  output logic [DW-1:0]  ex_b,
  output logic [DW-1:0]  ex_imm,
  output logic [7:0]     bubble_cnt
);

  logic          rs1Hazard;
  logic          rs2Hazard;
  logic          loadUse;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic          insertBubble;
  logic [7:0]    bubbleCntNext;

  // A load in EX delivers its data too late for the instruction in ID, which
  // must wait one cycle. A store's data source (rs2) counts as a use too.
  assign rs1Hazard = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2Hazard = id_rs2_used && (id_rs2 == ex_rd);
  assign loadUse   = id_valid && ex_valid && ex_mem_read && (rs1Hazard || rs2Hazard);

  // A flushed ID instruction is dead, so holding it would be pointless.
  // During reset ex_valid is 0, so stall is already 0.
  assign stall = loadUse && !flush;

  // Writeback bypass. Register 0 is an ordinary register here.
  assign op1 = (wb_reg_write && (wb_addr == id_rs1)) ? wb_data : rf_data1;
  assign op2 = (wb_reg_write && (wb_addr == id_rs2)) ? wb_data : rf_data2;

  assign insertBubble  = flush || stall;
  assign bubbleCntNext = (bubble_cnt == 8'hFF) ? bubble_cnt : bubble_cnt + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_use_imm   <= 1'b0;
      ex_alu_op    <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_imm       <= '0;
      bubble_cnt   <= '0;
    end else if (insertBubble || !id_valid) begin
      // A bubble and an empty ID slot both load an all-zero EX entry.
      // Only a bubble is counted.
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_use_imm   <= 1'b0;
      ex_alu_op    <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_imm       <= '0;
      if (insertBubble) begin
        bubble_cnt <= bubbleCntNext;
      end
    end else begin
      ex_valid     <= 1'b1;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      ex_use_imm   <= id_use_imm;
      ex_alu_op    <= id_alu_op;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_a         <= op1;
      ex_b         <= op2;
      ex_imm       <= id_imm;
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 8-bit pipelined core. Sits directly downstream of the register file: captures its two combinational read ports plus the decoded control fields, and presents them to EX.
- Also detects load-use hazards (stalls IF/ID and inserts a bubble), applies branch flushes, and bypasses a same-cycle writeback onto the read data.

Parameters:
- DW, 8, datapath width (register data, immediate).
- AW, 3, register address width (8 registers).
- OPW, 3, ALU operation code width.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; the block is held in reset while reset=0.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs1, id_rs2  in  AW  source addresses (also drive RegFile ReadAddr1/2).
- id_rs1_used, id_rs2_used  in  1  instruction actually reads that source.
- id_rd  in  AW  destination address.
- id_reg_write, id_mem_read, id_mem_write, id_use_imm  in  1  decoded controls.
- id_alu_op  in  OPW  ALU operation.
- id_imm  in  DW  immediate.
- rf_data1, rf_data2  in  DW  RegFile Data1/Data2.
- wb_reg_write  in  1  writeback valid (same signal as RegFile RegWrite).
- wb_addr  in  AW  writeback address.
- wb_data  in  DW  writeback data.
- flush  in  1  branch taken in EX; kill ID instruction.
- stall  out  1  combinational; freeze PC and IF/ID this cycle.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_use_imm  out  1  registered controls.
- ex_alu_op  out  OPW  registered.
- ex_rs1, ex_rs2, ex_rd  out  AW  registered addresses (for EX forwarding).
- ex_a, ex_b  out  DW  registered operands (ex_b is the register value; the immediate mux lives in EX).
- ex_imm  out  DW  registered immediate.
- bubble_cnt  out  8  saturating count of bubbles inserted.

Behaviour:
- Reset (reset=0, asynchronous): every ex_* output is 0, bubble_cnt is 0. stall is 0 while in reset.
- Hazard, combinational:
  - stall = id_valid & ex_valid & ex_mem_read & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - flush gates stall to 0 (the ID instruction is dead anyway).
- Bypass, combinational:
  - op1 = (wb_reg_write & wb_addr==id_rs1) ? wb_data : rf_data1; op2 likewise for rs2.
  - Register 0 is not special; bypass applies to all 8 addresses.
- Update each posedge, priority order:
  1. flush=1: load a bubble. ex_valid=0, ex_reg_write/mem_read/mem_write=0; data fields don't-care, driven to 0. bubble_cnt += 1.
  2. stall=1: load a bubble as in 1; bubble_cnt += 1. The upstream holds ID, so the same instruction is presented again next cycle.
  3. id_valid=0: ex_valid=0, all controls 0, bubble_cnt unchanged.
  4. Otherwise: capture ex_valid=1, all id_* controls and addresses, ex_a=op1, ex_b=op2, ex_imm=id_imm.
- Latency: 1 cycle from ID to EX. A load-use hazard costs exactly 1 bubble: after the bubble, ex_mem_read=0, so stall deasserts.
- bubble_cnt saturates at 255; it never wraps.
- Controls are only asserted when ex_valid=1. Invariant: ex_valid=0 implies ex_reg_write=ex_mem_read=ex_mem_write=0.
- Reset asserted mid-stall: outputs clear immediately (no clock needed), and stall drops because ex_valid=0.
- Store data hazard: a load followed by a store that uses rs2 stalls like any other use.

Test Plan:
- Reset: drive reset=0 mid-stream with ex_valid=1 -> all ex_* and bubble_cnt read 0 before the next clk edge; stall=0.
- Pass-through: id_valid=1, rs1=2, rs2=5, rf_data1=0x12, rf_data2=0x34, alu_op=3, imm=0x7F -> next cycle ex_a=0x12, ex_b=0x34, ex_alu_op=3, ex_imm=0x7F, ex_valid=1, stall=0 throughout.
- Load-use: load with rd=4 in EX (ex_mem_read=1), ID reads rs2=4 with rs2_used=1 -> stall=1 for one cycle; the next edge gives ex_valid=0 and bubble_cnt=1; the following edge captures the ID instruction with ex_valid=1.
- Unused source: same as the load-use case but rs2_used=0 -> stall=0, no bubble.
- WB bypass: wb_reg_write=1, wb_addr=3, wb_data=0xA5, id_rs1=3, rf_data1=0x00 -> ex_a=0xA5. With wb_reg_write=0 -> ex_a=0x00.
- Flush priority and saturation: flush=1 together with a hazard condition -> stall=0, ex_valid=0, bubble_cnt +1. Assert flush for 300 cycles -> bubble_cnt holds at 255.
